// File: rtl/uart_rx_ctrl.sv
// UART receive controller: arms an external receiver, captures bytes into a FIFO and
// backs off after framing errors. Optional idle timeout pulse when RX_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
  parameter int DEPTH       = 4,
  parameter int RECOVER_CYC = 16,
  parameter int TIMEOUT     = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  output logic       o_rx_ce,
  output logic       o_rx_rd,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_rdc,
  input  logic       i_rx_error,
  input  logic       i_pop,
  output logic [7:0] o_dout,
  output logic       o_empty,
  output logic       o_full,
  output logic       o_overrun,
  output logic [7:0] o_err_cnt,
  output logic       o_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(RECOVER_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_RECOVER} state_t;

  state_t          r_state, w_next;
  logic            r_rdc_d, r_err_d;
  logic [7:0]      r_data;
  logic [RW-1:0]   r_rec_cnt;
  logic [7:0]      r_err_cnt;
  logic            r_overrun;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic w_rdc_rise, w_err_rise, w_enter_rec, w_push, w_pop, w_capture;

  assign w_rdc_rise  = i_rx_rdc & ~r_rdc_d;
  assign w_err_rise  = i_rx_error & ~r_err_d;
  assign w_enter_rec = (r_state == S_ARM) & w_err_rise;
  assign w_capture   = (r_state == S_CAPTURE);
  assign w_pop       = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a capture at full still lands.
  assign w_push      = w_capture & (~o_full | w_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_en) w_next = S_ARM;
      S_ARM: begin
        if (w_err_rise)      w_next = S_RECOVER;
        else if (w_rdc_rise) w_next = S_CAPTURE;
        else if (!i_en)      w_next = S_IDLE;
      end
      S_CAPTURE: w_next = i_en ? S_ARM : S_IDLE;
      S_RECOVER: if (r_rec_cnt == '0) w_next = i_en ? S_ARM : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_rx_ce = (r_state == S_ARM);
    o_rx_rd = (r_state == S_ARM);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdc_d   <= 1'b0;
      r_err_d   <= 1'b0;
      r_data    <= '0;
      r_rec_cnt <= '0;
      r_err_cnt <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_rdc_d <= i_rx_rdc;
      r_err_d <= i_rx_error;
      if ((r_state == S_ARM) && w_rdc_rise) r_data <= i_rx_data;
      if (w_enter_rec) begin
        r_rec_cnt <= RW'(RECOVER_CYC - 1);
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end else if ((r_state == S_RECOVER) && (r_rec_cnt != '0)) begin
        r_rec_cnt <= r_rec_cnt - RW'(1);
      end
      if (w_capture && !w_push) r_overrun <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout    = r_mem[r_rd_ptr];
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_overrun = r_overrun;
  assign o_err_cnt = r_err_cnt;

`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_to_cnt;
  logic          r_timeout;

  // Down-counter reloads on any FIFO activity; the pulse fires on the 1 -> 0 step only.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (w_push || w_pop) begin
        r_to_cnt <= TW'(TIMEOUT);
      end else if (!o_empty && (r_to_cnt != '0)) begin
        r_to_cnt <= r_to_cnt - TW'(1);
        if (r_to_cnt == TW'(1)) r_timeout <= 1'b1;
      end
    end
  end

  assign o_timeout = r_timeout;
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (DEPTH=4, RECOVER_CYC=16, TIMEOUT=1024).
module tb_uart_rx_ctrl;
  logic       clk = 1'b0;
  logic       rst, en, rx_ce, rx_rd, rx_rdc, rx_error, pop;
  logic       empty, full, overrun, timeout;
  logic [7:0] rx_data, dout, err_cnt;
  int         n_chk = 0;
  int         n_fail = 0;
  int         n;
  logic       to_seen = 1'b0;

  uart_rx_ctrl #(.DEPTH(4), .RECOVER_CYC(16), .TIMEOUT(1024)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .o_rx_ce(rx_ce), .o_rx_rd(rx_rd),
    .i_rx_data(rx_data), .i_rx_rdc(rx_rdc), .i_rx_error(rx_error), .i_pop(pop),
    .o_dout(dout), .o_empty(empty), .o_full(full), .o_overrun(overrun),
    .o_err_cnt(err_cnt), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (timeout === 1'b1) to_seen = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_rdc  = 1'b1;
    tick();
    tick();
    rx_rdc  = 1'b0;
    tick();
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] e);
    chk(tag, dout, e);
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic do_error();
    rx_error = 1'b1;
    tick();
    rx_error = 1'b0;
    repeat (17) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; rx_data = 8'h00; rx_rdc = 1'b0; rx_error = 1'b0; pop = 1'b0;
    repeat (3) tick();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_overrun", overrun, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_rx_ce", rx_ce, 0);
    chk("rst_timeout", timeout, 0);

    en = 1'b1; rst = 1'b0;
    chk("idle_rx_ce", rx_ce, 0);
    tick();
    chk("arm_after_rst", rx_ce, 1);
    chk("arm_rx_rd", rx_rd, 1);

    // latency: byte visible two edges after the rise
    rx_data = 8'h55; rx_rdc = 1'b1;
    tick();
    chk("lat_edge1_empty", empty, 1);
    chk("capture_rx_ce", rx_ce, 0);
    tick();
    chk("lat_edge2_empty", empty, 0);
    chk("lat_edge2_dout", dout, 8'h55);
    rx_rdc = 1'b0;
    tick();
    send_byte(8'hA3);
    send_byte(8'h0F);
    chk("three_dout", dout, 8'h55);
    chk("three_full", full, 0);
    chk("three_err_cnt", err_cnt, 0);

    send_byte(8'h3C);
    chk("four_full", full, 1);
    chk("pre_ovr_overrun", overrun, 0);
    send_byte(8'h77);
    chk("ovr_overrun", overrun, 1);
    chk("ovr_full", full, 1);
    chk("ovr_dout", dout, 8'h55);
    pop_chk("pop0", 8'h55);
    pop_chk("pop1", 8'hA3);
    pop_chk("pop2", 8'h0F);
    pop_chk("pop3", 8'h3C);
    chk("drained_empty", empty, 1);
    chk("overrun_sticky", overrun, 1);

    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("pop_empty_empty", empty, 1);
    chk("pop_empty_full", full, 0);
    send_byte(8'h11);
    chk("after_empty_pop_dout", dout, 8'h11);

    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    chk("refill_full", full, 1);
    rx_data = 8'h99; rx_rdc = 1'b1;
    tick();
    pop = 1'b1;
    tick();
    pop = 1'b0; rx_rdc = 1'b0;
    tick();
    chk("pp_full_full", full, 1);
    pop_chk("pp_full_pop0", 8'h22);
    pop_chk("pp_full_pop1", 8'h33);
    pop_chk("pp_full_pop2", 8'h44);
    pop_chk("pp_full_pop3", 8'h99);
    chk("pp_full_drained", empty, 1);

    rx_data = 8'h5A; rx_rdc = 1'b1;
    tick();
    pop = 1'b1;
    tick();
    pop = 1'b0; rx_rdc = 1'b0;
    tick();
    chk("pp_empty_empty", empty, 0);
    chk("pp_empty_full", full, 0);
    pop_chk("pp_empty_pop", 8'h5A);
    chk("pp_empty_drained", empty, 1);

    // framing error: disarm window length
    rx_error = 1'b1;
    tick();
    chk("err1_cnt", err_cnt, 1);
    n = 0;
    while (rx_ce == 1'b0 && n < 40) begin
      n++;
      tick();
    end
    chk("recover_len", n, 16);
    repeat (3) tick();
    chk("err_held_no_repeat", rx_ce, 1);
    chk("err_held_cnt", err_cnt, 1);
    rx_error = 1'b0;
    tick();

    rx_data = 8'hEE; rx_rdc = 1'b1; rx_error = 1'b1;
    tick();
    chk("both_cnt", err_cnt, 2);
    chk("both_rx_ce", rx_ce, 0);
    rx_rdc = 1'b0; rx_error = 1'b0;
    repeat (16) tick();
    chk("both_no_push", empty, 1);
    chk("both_rearm", rx_ce, 1);

    en = 1'b0;
    tick();
    chk("en_low_idle", rx_ce, 0);
    send_byte(8'h66);
    chk("idle_no_push", empty, 1);
    en = 1'b1;
    tick();
    chk("en_high_arm", rx_ce, 1);

    for (int i = 0; i < 254; i++) do_error();
    chk("sat_256", err_cnt, 255);
    do_error();
    chk("sat_257", err_cnt, 255);

    send_byte(8'h42);
    chk("pre_rst_empty", empty, 0);
    rx_error = 1'b1;
    tick();
    tick();
    rx_error = 1'b0;
    chk("pre_rst_recover", rx_ce, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_rec_err_cnt", err_cnt, 0);
    chk("rst_rec_rx_ce", rx_ce, 0);
    chk("rst_rec_empty", empty, 1);
    chk("rst_rec_full", full, 0);
    chk("rst_rec_overrun", overrun, 0);
    chk("rst_rec_dout", dout, 8'h00);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_rec_arm", rx_ce, 1);

`ifdef RX_TIMEOUT_EN
    rx_data = 8'h7E; rx_rdc = 1'b1;
    tick();
    tick();
    n = 0;
    while (timeout == 1'b0 && n < 1100) begin
      tick();
      n++;
    end
    chk("timeout_delay", n, 1024);
    to_seen = 1'b0;
    repeat (200) tick();
    chk("timeout_single", to_seen, 0);
    rx_rdc = 1'b0;
`else
    repeat (50) tick();
    chk("timeout_never", to_seen, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
